// File: rtl/nx_ia_arb_pkg.sv
// Shared types for the indirect-access RAM arbiter: owner encoding and
// read-return pipeline entry.
package nx_ia_arb_pkg;

    localparam int NX_IA_ARB_MAX_HW = 8;

    typedef enum logic [3:0] {
        HW0 = 4'd0,
        HW1 = 4'd1,
        HW2 = 4'd2,
        HW3 = 4'd3,
        HW4 = 4'd4,
        HW5 = 4'd5,
        HW6 = 4'd6,
        HW7 = 4'd7,
        SW  = 4'd8
    } ia_owner_e;

    typedef struct packed {
        logic      valid;
        ia_owner_e owner;
    } ia_rdpipe_t;

    // Maps a hardware requester index onto its owner tag.
    function automatic ia_owner_e hw_owner(input int idx);
        logic [3:0] idx_v;
        idx_v = idx[3:0];
        return ia_owner_e'(idx_v);
    endfunction

endpackage

// File: rtl/nx_ia_arb_rr.sv
// Round-robin picker: one-hot grant to the first request at or above the
// pointer (wrapping), plus the pointer value that follows that grant.
module nx_ia_arb_rr #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] ptr_nxt_o
);

    logic [N-1:0] mask_s;
    logic [N-1:0] upper_s;
    logic [N-1:0] src_s;

    // Pick the lowest request at or above ptr, else wrap to the lowest overall.
    always_comb begin
        mask_s  = ~((N'(1) << ptr_i) - N'(1));
        upper_s = req_i & mask_s;
        if (|upper_s) begin
            src_s = upper_s;
        end else begin
            src_s = req_i;
        end
        gnt_o     = src_s & (~src_s + N'(1));
        ptr_nxt_o = ptr_i;
        for (int i = 0; i < N; i++) begin
            if (gnt_o[i]) begin
                ptr_nxt_o = (i == N - 1) ? '0 : PW'(i + 1);
            end else begin
            end
        end
    end

endmodule

// File: rtl/nx_ia_mem_arbiter.sv
// Arbiter sharing one single-port table RAM between the software indirect
// access controller and N_HW_REQ datapath requesters.
// Optional performance counters: define NX_IA_MEM_ARBITER_PERF_EN.
module nx_ia_mem_arbiter
    import nx_ia_arb_pkg::*;
#(
    parameter int N_HW_REQ    = 2,
    parameter int N_ADDR_BITS = 9,
    parameter int N_DATA_BITS = 96,
    parameter int RD_LATENCY  = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            sw_cs,
    input  logic                            sw_we,
    input  logic                            sw_ce,
    input  logic [N_ADDR_BITS-1:0]          sw_add,
    input  logic [N_DATA_BITS-1:0]          sw_wdat,
    input  logic                            yield,
    output logic                            grant,
    output logic [N_DATA_BITS-1:0]          sw_rdat,
    input  logic [N_HW_REQ-1:0]             hw_req,
    input  logic [N_HW_REQ-1:0]             hw_we,
    input  logic [N_HW_REQ*N_ADDR_BITS-1:0] hw_addr,
    input  logic [N_HW_REQ*N_DATA_BITS-1:0] hw_wdat,
    output logic [N_HW_REQ-1:0]             hw_gnt,
    output logic [N_HW_REQ-1:0]             hw_rvalid,
    output logic [N_DATA_BITS-1:0]          hw_rdat,
    output logic                            mem_cs,
    output logic                            mem_we,
    output logic                            mem_ce,
    output logic [N_ADDR_BITS-1:0]          mem_add,
    output logic [N_DATA_BITS-1:0]          mem_wdat,
    input  logic [N_DATA_BITS-1:0]          mem_rdat
`ifdef NX_IA_MEM_ARBITER_PERF_EN
    ,
    output logic [15:0]                     perf_sw_wait,
    output logic [15:0]                     perf_hw_conflict
`else
`endif
);

    localparam int RR_W = (N_HW_REQ > 1) ? $clog2(N_HW_REQ) : 1;

    logic                active_q;
    logic [RR_W-1:0]     rr_q;
    logic [RR_W-1:0]     rr_d;
    logic [RR_W-1:0]     rr_nxt_s;
    logic [N_HW_REQ-1:0] rr_gnt_s;
    logic                sw_win_s;
    logic                hw_sel_s;
    ia_owner_e           owner_s;
    ia_rdpipe_t          pipe_in_s;
    ia_rdpipe_t          pipe_q [RD_LATENCY];

    nx_ia_arb_rr #(
        .N  (N_HW_REQ),
        .PW (RR_W)
    ) u_rr (
        .req_i     (hw_req),
        .ptr_i     (rr_q),
        .gnt_o     (rr_gnt_s),
        .ptr_nxt_o (rr_nxt_s)
    );

    // Software wins on yield, or when no hardware requester is asking.
    always_comb begin
        sw_win_s = active_q && sw_cs && (yield || (hw_req == '0));
        hw_sel_s = active_q && !sw_win_s && (hw_req != '0);
        grant    = sw_win_s;
        if (hw_sel_s) begin
            hw_gnt = rr_gnt_s;
            rr_d   = rr_nxt_s;
        end else begin
            hw_gnt = '0;
            rr_d   = rr_q;
        end
    end

    // RAM port mux for the granted owner; compare-enable only from software.
    always_comb begin
        mem_cs   = 1'b0;
        mem_we   = 1'b0;
        mem_ce   = 1'b0;
        mem_add  = '0;
        mem_wdat = '0;
        owner_s  = SW;
        if (sw_win_s) begin
            mem_cs   = 1'b1;
            mem_we   = sw_we;
            mem_ce   = sw_ce;
            mem_add  = sw_add;
            mem_wdat = sw_wdat;
        end else if (hw_sel_s) begin
            mem_cs = 1'b1;
            for (int i = 0; i < N_HW_REQ; i++) begin
                if (rr_gnt_s[i]) begin
                    mem_we   = hw_we[i];
                    mem_add  = hw_addr[i*N_ADDR_BITS +: N_ADDR_BITS];
                    mem_wdat = hw_wdat[i*N_DATA_BITS +: N_DATA_BITS];
                    owner_s  = hw_owner(i);
                end else begin
                end
            end
        end else begin
        end
        pipe_in_s.valid = mem_cs && !mem_we;
        pipe_in_s.owner = owner_s;
    end

    // Enable latch, round-robin pointer and read-return pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            rr_q     <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            active_q  <= 1'b1;
            rr_q      <= rr_d;
            pipe_q[0] <= pipe_in_s;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Software reads carry the SW tag and never raise a hardware valid.
    always_comb begin
        hw_rvalid = '0;
        for (int i = 0; i < N_HW_REQ; i++) begin
            if (pipe_q[RD_LATENCY-1].valid && (pipe_q[RD_LATENCY-1].owner == hw_owner(i))) begin
                hw_rvalid[i] = 1'b1;
            end else begin
                hw_rvalid[i] = 1'b0;
            end
        end
    end

    assign sw_rdat = mem_rdat;
    assign hw_rdat = mem_rdat;

`ifdef NX_IA_MEM_ARBITER_PERF_EN
    logic [15:0] sw_wait_q;
    logic [15:0] sw_wait_d;
    logic [15:0] hw_conf_q;
    logic [15:0] hw_conf_d;
    logic        multi_req_s;

    // Saturating event counters.
    always_comb begin
        multi_req_s = (hw_req & (hw_req - N_HW_REQ'(1))) != '0;
        if (sw_cs && !grant && (sw_wait_q != 16'hFFFF)) begin
            sw_wait_d = sw_wait_q + 16'd1;
        end else begin
            sw_wait_d = sw_wait_q;
        end
        if (multi_req_s && (hw_conf_q != 16'hFFFF)) begin
            hw_conf_d = hw_conf_q + 16'd1;
        end else begin
            hw_conf_d = hw_conf_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_wait_q <= 16'd0;
            hw_conf_q <= 16'd0;
        end else begin
            sw_wait_q <= sw_wait_d;
            hw_conf_q <= hw_conf_d;
        end
    end

    assign perf_sw_wait     = sw_wait_q;
    assign perf_hw_conflict = hw_conf_q;
`else
`endif

endmodule
